rf_port_arbiter: RTL

Shares the core's single-read/single-write register file (32 × 32-bit, writes committed on the falling clock edge, combinational read, register 0 hard-wired to zero) among multiple operand readers and two writeback sources. It sits between the operand-fetch/writeback stages and the register file. It grants one read per cycle by round-robin and returns the data one cycle later. It grants one write per cycle by LSU-over-ALU priority with an optional starvation guard.

---
 rtl/rf_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/rf_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file port arbiter.
// Fixed register-file geometry and the writeback request bundle.
package rf_arb_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef logic [RF_AW-1:0] rf_adr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_adr_t  adr;
    rf_data_t data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over N requesters.
// Search starts at ptr and wraps; next_ptr points past the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);

  logic hit;

  always_comb begin
    gnt     = '0;
    nxt_ptr = ptr;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      automatic int idx;
      idx = (int'(ptr) + i) % N;
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        nxt_ptr  = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin read and LSU-priority write sharing of a 1R1W regfile.
// Define RF_ARB_STARVE_GUARD_EN to let a starved ALU force a win.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_RD     = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD-1:0]       rd_req_valid,
  input  logic [NUM_RD*RF_AW-1:0] rd_req_adr,
  output logic [NUM_RD-1:0]       rd_req_ready,
  output logic [NUM_RD-1:0]       rd_rsp_valid,
  output logic [RF_DW-1:0]        rd_rsp_data,
  input  logic                    alu_wr_valid,
  input  logic [RF_AW-1:0]        alu_wr_adr,
  input  logic [RF_DW-1:0]        alu_wr_data,
  output logic                    alu_wr_ready,
  input  logic                    lsu_wr_valid,
  input  logic [RF_AW-1:0]        lsu_wr_adr,
  input  logic [RF_DW-1:0]        lsu_wr_data,
  output logic                    lsu_wr_ready,
  output logic [RF_AW-1:0]        rf_adr,
  input  logic [RF_DW-1:0]        rf_rs,
  output logic                    rf_we,
  output logic [RF_AW-1:0]        rf_w_adr,
  output logic [RF_DW-1:0]        rf_w_data
);

  localparam int PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  if (NUM_RD < 2 || NUM_RD > 8 || STARVE_LIM < 1) begin : g_cfg_err
    $error("rf_port_arbiter: parameter out of range");
  end

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     nxt_ptr;
  logic [NUM_RD-1:0] gnt;

  rr_arbiter #(
    .N  (NUM_RD),
    .PW (PW)
  ) u_rr (
    .req     (rd_req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .nxt_ptr (nxt_ptr)
  );

  assign rd_req_ready = rst_n ? gnt : '0;

  always_comb begin
    rf_adr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_req_ready[i]) begin
        rf_adr = rd_req_adr[i*RF_AW +: RF_AW];
      end
    end
  end

  // Regfile writes land at the falling edge, so rf_rs already
  // reflects a same-cycle write when it is captured here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      rd_rsp_valid <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_req_ready;
      if (|rd_req_ready) begin
        ptr         <= nxt_ptr;
        rd_rsp_data <= rf_rs;
      end
    end
  end

  wr_req_t alu_req;
  wr_req_t lsu_req;
  wr_req_t win;
  logic    force_alu;
  logic    alu_win;
  logic    lsu_win;

  assign alu_req = '{valid: alu_wr_valid, adr: alu_wr_adr, data: alu_wr_data};
  assign lsu_req = '{valid: lsu_wr_valid, adr: lsu_wr_adr, data: lsu_wr_data};

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0] starve_cnt;

  assign force_alu = (starve_cnt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_wr_ready) begin
      starve_cnt <= '0;
    end else if (alu_wr_valid && starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_alu = 1'b0;
`endif

  assign alu_win = rst_n && alu_req.valid && (!lsu_req.valid || force_alu);
  assign lsu_win = rst_n && lsu_req.valid && !alu_win;

  always_comb begin
    win       = alu_win ? alu_req : lsu_req;
    win.valid = alu_win || lsu_win;
  end

  assign alu_wr_ready = alu_win;
  assign lsu_wr_ready = lsu_win;

  // r0 writes still handshake but never reach the regfile.
  assign rf_we     = win.valid && (win.adr != '0);
  assign rf_w_adr  = win.adr;
  assign rf_w_data = win.data;

endmodule
